// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle mc_core CPU: instruction fields,
// opcode/funct encodings, FSM state codes and ALU operations.
package mc_pkg;

    localparam int unsigned INSTR_W   = 16;
    localparam int unsigned OP_W      = 4;
    localparam int unsigned OP_LSB    = 12;
    localparam int unsigned RS_LSB    = 9;
    localparam int unsigned RT_LSB    = 6;
    localparam int unsigned RD_LSB    = 3;
    localparam int unsigned FUNCT_LSB = 0;
    localparam int unsigned REG_IDX_W = 3;
    localparam int unsigned FUNCT_W   = 3;
    localparam int unsigned IMM_W     = 6;
    localparam int unsigned TGT_W     = 12;

    typedef enum logic [3:0] {
        OP_RTYPE = 4'd0,
        OP_ADDI  = 4'd1,
        OP_LW    = 4'd2,
        OP_SW    = 4'd3,
        OP_BEQ   = 4'd4,
        OP_BNE   = 4'd5,
        OP_BLT   = 4'd6,
        OP_BGT   = 4'd7,
        OP_J     = 4'd8,
        OP_HALT  = 4'd15
    } opcode_e;

    typedef enum logic [2:0] {
        FN_ADD = 3'd0,
        FN_SUB = 3'd1,
        FN_AND = 3'd2,
        FN_OR  = 3'd3,
        FN_XOR = 3'd4,
        FN_SLT = 3'd5,
        FN_SLL = 3'd6,
        FN_SRL = 3'd7
    } funct_e;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT,
        ALU_SLL,
        ALU_SRL
    } alu_op_e;

    function automatic alu_op_e funct_to_alu(input logic [FUNCT_W-1:0] funct);
        alu_op_e op;
        case (funct)
            FN_ADD:  op = ALU_ADD;
            FN_SUB:  op = ALU_SUB;
            FN_AND:  op = ALU_AND;
            FN_OR:   op = ALU_OR;
            FN_XOR:  op = ALU_XOR;
            FN_SLT:  op = ALU_SLT;
            FN_SLL:  op = ALU_SLL;
            default: op = ALU_SRL;
        endcase
        return op;
    endfunction

    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        return op inside {OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE,
                          OP_BLT, OP_BGT, OP_J, OP_HALT};
    endfunction

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU for mc_core: result plus equality and signed
// less/greater flags comparing the two operands.
module mc_alu
    import mc_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  alu_op_e           op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o,
    output logic              lt_o,
    output logic              gt_o
);

    logic signed_lt;
    logic signed_gt;

    assign signed_lt = $signed(a_i) < $signed(b_i);
    assign signed_gt = $signed(a_i) > $signed(b_i);

    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_ADD: result_o = a_i + b_i;
            ALU_SUB: result_o = a_i - b_i;
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_XOR: result_o = a_i ^ b_i;
            ALU_SLT: result_o = DATA_W'(signed_lt);
            ALU_SLL: result_o = a_i << b_i[3:0];
            ALU_SRL: result_o = a_i >> b_i[3:0];
            default: result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);
    assign lt_o   = signed_lt;
    assign gt_o   = signed_gt;

endmodule

// File: rtl/mc_core.sv
// Multi-cycle 16-bit-ISA CPU core with a configurable data width and
// register count, sharing one req/ready memory port for fetch and data.
module mc_core
    import mc_pkg::*;
#(
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       ADDR_W   = 16,
    parameter int unsigned       NREG     = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              illegal,
    output logic [2:0]        state
);

    localparam logic [ADDR_W-1:0] J_KEEP_MASK = ~ADDR_W'({TGT_W{1'b1}});

    state_e              state_q, state_d;
    logic                run_q;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   alu_q, alu_d;
    logic [DATA_W-1:0]   mdr_q, mdr_d;
    logic                illegal_q, illegal_d;
    logic [DATA_W-1:0]   regs_q [NREG];

    logic                 rf_we;
    logic [REG_IDX_W-1:0] rf_waddr;
    logic [DATA_W-1:0]    rf_wdata;

    logic [OP_W-1:0]      op;
    logic [REG_IDX_W-1:0] rs, rt, rd;
    logic [FUNCT_W-1:0]   funct;
    logic [IMM_W-1:0]     imm6;
    logic [TGT_W-1:0]     tgt12;
    logic [DATA_W-1:0]    imm_data;
    logic [ADDR_W-1:0]    imm_addr;

    assign op       = ir_q[OP_LSB +: OP_W];
    assign rs       = ir_q[RS_LSB +: REG_IDX_W];
    assign rt       = ir_q[RT_LSB +: REG_IDX_W];
    assign rd       = ir_q[RD_LSB +: REG_IDX_W];
    assign funct    = ir_q[FUNCT_LSB +: FUNCT_W];
    assign imm6     = ir_q[IMM_W-1:0];
    assign tgt12    = ir_q[TGT_W-1:0];
    assign imm_data = {{(DATA_W-IMM_W){imm6[IMM_W-1]}}, imm6};
    assign imm_addr = {{(ADDR_W-IMM_W){imm6[IMM_W-1]}}, imm6};

    logic is_branch, is_lw, is_sw;
    assign is_branch = op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGT};
    assign is_lw     = (op == OP_LW);
    assign is_sw     = (op == OP_SW);

    // Register file read: r0 and indices beyond NREG read as zero.
    logic [DATA_W-1:0] rs_val, rt_val;
    always_comb begin
        rs_val = '0;
        rt_val = '0;
        if (rs != '0 && 32'(rs) < NREG) rs_val = regs_q[rs];
        if (rt != '0 && 32'(rt) < NREG) rt_val = regs_q[rt];
    end

    alu_op_e           alu_op;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_res;
    logic              alu_zero, alu_lt, alu_gt;

    always_comb begin
        alu_op = ALU_ADD;
        alu_b  = imm_data;
        if (op == OP_RTYPE) begin
            alu_op = funct_to_alu(funct);
            alu_b  = b_q;
        end else if (is_branch) begin
            alu_op = ALU_SUB;
            alu_b  = b_q;
        end
    end

    mc_alu #(.DATA_W(DATA_W)) u_alu (
        .op_i     (alu_op),
        .a_i      (a_q),
        .b_i      (alu_b),
        .result_o (alu_res),
        .zero_o   (alu_zero),
        .lt_o     (alu_lt),
        .gt_o     (alu_gt)
    );

    logic              br_taken;
    logic [ADDR_W-1:0] pc_inc, br_target, j_target, data_addr;

    always_comb begin
        case (op)
            OP_BEQ:  br_taken = alu_zero;
            OP_BNE:  br_taken = ~alu_zero;
            OP_BLT:  br_taken = alu_lt;
            OP_BGT:  br_taken = alu_gt;
            default: br_taken = 1'b0;
        endcase
    end

    assign pc_inc    = pc_q + ADDR_W'(1);
    assign br_target = pc_inc + imm_addr;
    assign j_target  = (pc_q & J_KEEP_MASK) | ADDR_W'(tgt12);
    assign data_addr = ADDR_W'(alu_q);

    // run_q holds the bus idle for the first cycle out of reset; bus outputs
    // are forced to zero whenever no request is active.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_d     = alu_q;
        mdr_d     = mdr_q;
        illegal_d = illegal_q;
        rf_we     = 1'b0;
        rf_waddr  = rt;
        rf_wdata  = alu_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        case (state_q)
            ST_FETCH: begin
                if (run_q) begin
                    mem_req  = 1'b1;
                    mem_addr = pc_q;
                    if (mem_ready) begin
                        ir_d    = mem_rdata[INSTR_W-1:0];
                        state_d = ST_DECODE;
                    end
                end
            end
            ST_DECODE: begin
                a_d = rs_val;
                b_d = rt_val;
                if (!is_legal_op(op)) begin
                    illegal_d = 1'b1;
                    state_d   = ST_HALT;
                end else if (op == OP_HALT) begin
                    state_d = ST_HALT;
                end else if (op == OP_J) begin
                    pc_d    = j_target;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_d = alu_res;
                if (is_branch) begin
                    pc_d    = br_taken ? br_target : pc_inc;
                    state_d = ST_FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                mem_we   = is_sw;
                mem_addr = data_addr;
                if (is_sw) mem_wdata = b_q;
                if (mem_ready) begin
                    if (is_sw) begin
                        pc_d    = pc_inc;
                        state_d = ST_FETCH;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                rf_we    = 1'b1;
                rf_waddr = (op == OP_RTYPE) ? rd : rt;
                rf_wdata = is_lw ? mdr_q : alu_q;
                pc_d     = pc_inc;
                state_d  = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            run_q     <= 1'b0;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_q     <= '0;
            mdr_q     <= '0;
            illegal_q <= 1'b0;
            for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            run_q     <= 1'b1;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_q     <= alu_d;
            mdr_q     <= mdr_d;
            illegal_q <= illegal_d;
            if (rf_we && rf_waddr != '0 && 32'(rf_waddr) < NREG)
                regs_q[rf_waddr] <= rf_wdata;
        end
    end

    assign pc      = pc_q;
    assign halted  = (state_q == ST_HALT);
    assign illegal = illegal_q;
    assign state   = state_q;

endmodule

// File: tb/tb_mc_core.sv
// Directed self-checking bench for mc_core with a wait-state memory model.
module tb_mc_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_ready = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic [15:0] pc;
    logic        halted, illegal;
    logic [2:0]  state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] mem [65536];
    int          cyc = 0;
    int          fs [64];
    int          nf = 0;
    bit          infetch = 0;
    int          wcnt = 0;
    bit          pend = 0;
    logic [15:0] paddr, pwdata;
    logic        pwe;
    int          unstable = 0;

    mc_core #(
        .DATA_W   (16),
        .ADDR_W   (16),
        .NREG     (8),
        .RESET_PC (16'h0010)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .pc        (pc),
        .halted    (halted),
        .illegal   (illegal),
        .state     (state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic int waits_for(input logic [15:0] a);
        return (a < 16'h0010 || a == 16'h0014 || a == 16'h0015) ? 3 : 0;
    endfunction

    function automatic logic [15:0] enc_r(input int f, input int s, input int t, input int d);
        return {4'h0, 3'(s), 3'(t), 3'(d), 3'(f)};
    endfunction

    function automatic logic [15:0] enc_i(input int o, input int s, input int t, input int imm);
        return {4'(o), 3'(s), 3'(t), 6'(imm)};
    endfunction

    function automatic logic [15:0] enc_j(input int tgt);
        return {4'h8, 12'(tgt)};
    endfunction

    // Memory responder, bus-stability monitor and fetch-start timestamps.
    always @(negedge clk) begin
        if (mem_req && pend && (mem_addr != paddr || mem_we != pwe || mem_wdata != pwdata))
            unstable++;
        if (state == 3'd0 && mem_req && !infetch) begin
            if (nf < 64) fs[nf] = cyc;
            nf++;
            infetch = 1;
        end else if (state != 3'd0) begin
            infetch = 0;
        end
        if (!mem_req) begin
            mem_ready = 1'b0;
            wcnt = 0;
        end else begin
            if (mem_ready) begin
                mem_ready = 1'b0;
                wcnt = 0;
            end
            if (wcnt >= waits_for(mem_addr)) begin
                mem_ready = 1'b1;
                if (mem_we) mem[mem_addr] = mem_wdata;
                else        mem_rdata = mem[mem_addr];
            end else begin
                wcnt++;
            end
        end
        pend   = mem_req && !mem_ready;
        paddr  = mem_addr;
        pwe    = mem_we;
        pwdata = mem_wdata;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_state_pc(input logic [2:0] st, input logic [15:0] target,
                                 input string tag);
        int n = 0;
        bit hit = 0;
        while (!hit && n < 200) begin
            @(negedge clk); #1;
            n++;
            if (state == st && mem_req && pc == target) hit = 1;
        end
        check_eq(tag, 32'(hit), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        int reqs;
        for (int i = 0; i < 65536; i++) mem[i] = 16'hF000;
        mem[16'h0010] = enc_i(1, 0, 1, 5);
        mem[16'h0011] = enc_i(1, 0, 2, -3);
        mem[16'h0012] = enc_r(0, 1, 2, 3);
        mem[16'h0013] = enc_r(5, 2, 1, 4);
        mem[16'h0014] = enc_i(3, 0, 1, 2);
        mem[16'h0015] = enc_i(2, 0, 5, 2);
        mem[16'h0016] = enc_i(6, 2, 1, 2);
        mem[16'h0019] = enc_i(7, 2, 1, 2);
        mem[16'h001A] = enc_i(4, 0, 0, 0);
        mem[16'h001B] = enc_i(1, 0, 0, 7);
        mem[16'h001C] = enc_j(12'hFFF);
        mem[16'h0FFF] = enc_r(6, 1, 4, 6);
        mem[16'h1000] = enc_r(7, 2, 4, 7);
        mem[16'h1001] = enc_r(4, 1, 2, 3);
        mem[16'h1002] = enc_r(1, 1, 2, 4);
        mem[16'h1003] = enc_r(3, 1, 2, 5);
        mem[16'h1004] = enc_r(2, 6, 7, 1);
        mem[16'h1005] = enc_j(12'hABC);
        mem[16'h1ABC] = enc_i(5, 0, 0, 5);
        mem[16'h1ABD] = enc_i(4, 1, 6, 3);
        mem[16'h1AC1] = 16'hB000;

        repeat (3) @(negedge clk);
        #1;
        check_eq("rst pc", pc, 16'h0010);
        check_eq("rst state", state, 3'd0);
        check_eq("rst req", mem_req, 1'b0);
        check_eq("rst we", mem_we, 1'b0);
        check_eq("rst addr", mem_addr, 16'h0000);
        check_eq("rst wdata", mem_wdata, 16'h0000);
        check_eq("rst halted", halted, 1'b0);
        check_eq("rst illegal", illegal, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("req before first edge", mem_req, 1'b0);
        @(negedge clk); #1;
        check_eq("first req", mem_req, 1'b1);
        check_eq("first addr", mem_addr, 16'h0010);
        check_eq("first we", mem_we, 1'b0);

        wait_state_pc(3'd0, 16'h0014, "reach 0x14");
        check_eq("r1 addi", dut.regs_q[1], 16'h0005);
        check_eq("r2 addi neg", dut.regs_q[2], 16'hFFFD);
        check_eq("r3 add", dut.regs_q[3], 16'h0002);
        check_eq("r4 slt", dut.regs_q[4], 16'h0001);
        check_eq("cyc addi", fs[1] - fs[0], 4);
        check_eq("cyc add", fs[3] - fs[2], 4);
        check_eq("cyc slt", fs[4] - fs[3], 4);

        wait_state_pc(3'd0, 16'h0016, "reach 0x16");
        check_eq("mem sw", mem[2], 16'h0005);
        check_eq("r5 lw", dut.regs_q[5], 16'h0005);
        check_eq("cyc sw 3ws", fs[5] - fs[4], 10);
        check_eq("cyc lw 3ws", fs[6] - fs[5], 11);
        check_eq("bus stable", unstable, 0);

        wait_state_pc(3'd0, 16'h0019, "blt taken");
        wait_state_pc(3'd0, 16'h001A, "bgt not taken");
        wait_state_pc(3'd0, 16'h0FFF, "j 0xFFF");
        check_eq("r0 write ignored", dut.regs_q[0], 16'h0000);
        check_eq("cyc blt", fs[7] - fs[6], 3);
        check_eq("cyc beq imm0", fs[9] - fs[8], 3);
        check_eq("cyc addi r0", fs[10] - fs[9], 4);
        check_eq("cyc j", fs[11] - fs[10], 2);

        wait_state_pc(3'd0, 16'h1ABC, "j 0xABC");
        check_eq("r6 sll", dut.regs_q[6], 16'h000A);
        check_eq("r7 srl", dut.regs_q[7], 16'h7FFE);
        check_eq("r3 xor", dut.regs_q[3], 16'hFFF8);
        check_eq("r4 sub", dut.regs_q[4], 16'h0008);
        check_eq("r5 or", dut.regs_q[5], 16'hFFFD);
        check_eq("r1 and", dut.regs_q[1], 16'h000A);

        n = 0;
        while (!halted && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        check_eq("halted", halted, 1'b1);
        check_eq("illegal", illegal, 1'b1);
        check_eq("halt pc", pc, 16'h1AC1);
        check_eq("halt state", state, 3'd5);
        reqs = 0;
        repeat (4) begin
            @(negedge clk); #1;
            if (mem_req) reqs++;
        end
        check_eq("halt no req", reqs, 0);

        rst_n = 1'b0;
        #1;
        check_eq("clr illegal", illegal, 1'b0);
        check_eq("clr halted", halted, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        wait_state_pc(3'd3, 16'h0015, "lw in MEM");
        check_eq("lw mem addr", mem_addr, 16'h0002);
        rst_n = 1'b0;
        #1;
        check_eq("abort req", mem_req, 1'b0);
        check_eq("abort state", state, 3'd0);
        repeat (2) @(negedge clk);
        #1;
        check_eq("abort r5", dut.regs_q[5], 16'h0000);
        check_eq("abort pc", pc, 16'h0010);
        @(negedge clk);
        rst_n = 1'b1;
        wait_state_pc(3'd0, 16'h0011, "restart");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
